// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480 VGA raster constants and helpers
package vga_pkg;

  localparam int CNT_W       = 10;
  localparam int CLK_DIV_DEF = 4;

  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 29;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 521;

  // Origin shared with the colour/tile stage: pixel (0,0) sits at (HLEFT+1, VTOP+1)
  localparam int HLEFT = H_SYNC + H_BP;
  localparam int VTOP  = V_SYNC + V_BP;

  localparam int TILE_SIZE = 8;
  localparam int R         = 3;
  localparam int G         = 3;
  localparam int B         = 2;
  localparam int PIX_W     = R + G + B;

  typedef logic [CNT_W-1:0] cnt_t;

  // Visible window is open at the left/top edge and closed at the right/bottom edge
  function automatic logic in_window(input cnt_t pos, input cnt_t lo, input cnt_t hi);
    return (pos > lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// rtl/vga_pix_tick.sv - system clock divider producing the registered pixel-enable tick
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk1,
  input  logic rst,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_d  = div_q + DIV_W'(1);
    tick_d = 1'b0;
    if (div_q == DIV_MAX) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign pix_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters and sync/bright decode, zero skew outputs
// Optional frame counter output enabled by VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV_DEF,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL
) (
  input  logic        clk1,
  input  logic        rst,
  output logic        pix_tick,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        bright,
`ifdef VGA_FRAME_COUNT_EN
  output logic [15:0] frame_cnt,
  output logic        frame_start
`else
  output logic        frame_start
`endif
);

  import vga_pkg::*;

  if (CLK_DIV < 1 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
      H_SYNC + H_BP + H_ACTIVE >= H_TOTAL ||
      V_SYNC + V_BP + V_ACTIVE >= V_TOTAL) begin : g_bad_params
    $error("vga_timing_gen: timing parameters do not fit the 10-bit raster");
  end

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SW   = cnt_t'(H_SYNC);
  localparam cnt_t V_SW   = cnt_t'(V_SYNC);
  localparam cnt_t H_LO   = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_HI   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t V_LO   = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_HI   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);

  logic tick;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk1     (clk1),
    .rst      (rst),
    .pix_tick (tick)
  );

  cnt_t hcount_q, hcount_d;
  cnt_t vcount_q, vcount_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic bright_q, bright_d;
  logic frame_start_q, frame_start_d;

  // Sync/bright are decoded from the next counter values so they land with the counters
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + cnt_t'(1);
        end
      end else begin
        hcount_d = hcount_q + cnt_t'(1);
      end
    end
    hsync_d  = (hcount_d >= H_SW);
    vsync_d  = (vcount_d >= V_SW);
    bright_d = in_window(hcount_d, H_LO, H_HI) && in_window(vcount_d, V_LO, V_HI);
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      bright_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign pix_tick    = tick;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign bright      = bright_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench: default raster plus two reduced rasters
module tb_vga_timing_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       fs;
  } obs_t;

  typedef struct {
    int   k;
    obs_t exp;
  } vec_t;

  // Reduced rasters keep whole frames short
  localparam int B_CD = 3, B_HS = 4, B_HBP = 3, B_HA = 10, B_HT = 20;
  localparam int B_VS = 2, B_VBP = 2, B_VA = 5, B_VT = 12;
  localparam int C_CD = 1, C_HS = 3, C_HBP = 2, C_HA = 8, C_HT = 16;
  localparam int C_VS = 1, C_VBP = 2, C_VA = 5, C_VT = 10;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  int   ka = 0, kb = 0, kc = 0;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  logic       a_tick, a_hs, a_vs, a_br, a_fs;
  logic [9:0] a_h, a_v;
  logic       b_tick, b_hs, b_vs, b_br, b_fs;
  logic [9:0] b_h, b_v;
  logic       c_tick, c_hs, c_vs, c_br, c_fs;
  logic [9:0] c_h, c_v;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif

  obs_t a_obs, b_obs, c_obs;
  assign a_obs = {a_tick, a_h, a_v, a_hs, a_vs, a_br, a_fs};
  assign b_obs = {b_tick, b_h, b_v, b_hs, b_vs, b_br, b_fs};
  assign c_obs = {c_tick, c_h, c_v, c_hs, c_vs, c_br, c_fs};

  vga_timing_gen u_dut_a (
    .clk1(clk), .rst(rst_a), .pix_tick(a_tick), .hcount(a_h), .vcount(a_v),
    .hsync(a_hs), .vsync(a_vs), .bright(a_br),
`ifdef VGA_FRAME_COUNT_EN
    .frame_cnt(a_fc),
`endif
    .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(B_CD), .H_SYNC(B_HS), .H_BP(B_HBP), .H_ACTIVE(B_HA), .H_TOTAL(B_HT),
    .V_SYNC(B_VS), .V_BP(B_VBP), .V_ACTIVE(B_VA), .V_TOTAL(B_VT)
  ) u_dut_b (
    .clk1(clk), .rst(rst_b), .pix_tick(b_tick), .hcount(b_h), .vcount(b_v),
    .hsync(b_hs), .vsync(b_vs), .bright(b_br),
`ifdef VGA_FRAME_COUNT_EN
    .frame_cnt(b_fc),
`endif
    .frame_start(b_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(C_CD), .H_SYNC(C_HS), .H_BP(C_HBP), .H_ACTIVE(C_HA), .H_TOTAL(C_HT),
    .V_SYNC(C_VS), .V_BP(C_VBP), .V_ACTIVE(C_VA), .V_TOTAL(C_VT)
  ) u_dut_c (
    .clk1(clk), .rst(rst_c), .pix_tick(c_tick), .hcount(c_h), .vcount(c_v),
    .hsync(c_hs), .vsync(c_vs), .bright(c_br),
`ifdef VGA_FRAME_COUNT_EN
    .frame_cnt(c_fc),
`endif
    .frame_start(c_fs)
  );

  // Clock edges seen since reset was last released, per DUT
  always @(posedge clk or negedge rst_a) if (!rst_a) ka <= 0; else ka <= ka + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) kb <= 0; else kb <= kb + 1;
  always @(posedge clk or negedge rst_c) if (!rst_c) kc <= 0; else kc <= kc + 1;

  // Raster position after k clocks: ticks land on clocks cd, 2cd, ...; each tick moves
  // the raster one pixel on the following clock.
  function automatic int ticks_done(input int k, input int cd);
    return (k > cd) ? (k - 1) / cd : 0;
  endfunction

  function automatic obs_t model(input int k, input int cd, input int hs, input int hbp,
                                 input int ha, input int ht, input int vs, input int vbp,
                                 input int va, input int vt);
    obs_t o;
    int   t, pos, h, v;
    o = '0;
    if (k == 0) return o;
    t   = ticks_done(k, cd);
    pos = t % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    o.tick = (k >= cd) && (k % cd == 0);
    o.h    = 10'(h);
    o.v    = 10'(v);
    o.hs   = (h >= hs);
    o.vs   = (v >= vs);
    o.br   = (h > hs + hbp) && (h <= hs + hbp + ha) && (v > vs + vbp) && (v <= vs + vbp + va);
    o.fs   = (t > 0) && (pos == 0) && (k == cd * t + 1);
    return o;
  endfunction

  function automatic int model_fc(input int k, input int cd, input int ht, input int vt);
    return (ticks_done(k, cd) / (ht * vt)) % 65536;
  endfunction

  function automatic obs_t mk(input logic tick, input int h, input int v, input logic hs,
                              input logic vs, input logic br, input logic fs);
    obs_t o;
    o = {tick, 10'(h), 10'(v), hs, vs, br, fs};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("a_cycle", a_obs, model(ka, 4, 96, 48, 640, 800, 2, 29, 480, 521));
    check("b_cycle", b_obs, model(kb, B_CD, B_HS, B_HBP, B_HA, B_HT, B_VS, B_VBP, B_VA, B_VT));
    check("c_cycle", c_obs, model(kc, C_CD, C_HS, C_HBP, C_HA, C_HT, C_VS, C_VBP, C_VA, C_VT));
`ifdef VGA_FRAME_COUNT_EN
    check("a_fcnt", a_fc, model_fc(ka, 4, 800, 521));
    check("b_fcnt", b_fc, model_fc(kb, B_CD, B_HT, B_VT));
    check("c_fcnt", c_fc, model_fc(kc, C_CD, C_HT, C_VT));
`endif
  endtask

  vec_t vecs[12];

  initial begin
    int guard, k0, brc, tks;
    bit ok;

    vecs[0]  = '{0,    mk(0, 0,   0, 0, 0, 0, 0)};
    vecs[1]  = '{3,    mk(0, 0,   0, 0, 0, 0, 0)};
    vecs[2]  = '{4,    mk(1, 0,   0, 0, 0, 0, 0)};
    vecs[3]  = '{5,    mk(0, 1,   0, 0, 0, 0, 0)};
    vecs[4]  = '{8,    mk(1, 1,   0, 0, 0, 0, 0)};
    vecs[5]  = '{384,  mk(1, 95,  0, 0, 0, 0, 0)};
    vecs[6]  = '{385,  mk(0, 96,  0, 1, 0, 0, 0)};
    vecs[7]  = '{3200, mk(1, 799, 0, 1, 0, 0, 0)};
    vecs[8]  = '{3201, mk(0, 0,   1, 0, 0, 0, 0)};
    vecs[9]  = '{6400, mk(1, 799, 1, 1, 0, 0, 0)};
    vecs[10] = '{6401, mk(0, 0,   2, 0, 1, 0, 0)};
    vecs[11] = '{6981, mk(0, 145, 2, 1, 1, 0, 0)};

    // Default raster: reset state, then the release sequence against the table
    step();
    step();
    check("a_reset", a_obs, vecs[0].exp);
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 1; i < 12; i++) begin
      guard = 0;
      while (ka < vecs[i].k && guard < 8000) begin
        step();
        guard++;
      end
      check($sformatf("a_vec%0d", i), a_obs, vecs[i].exp);
    end

    // Reduced raster B: first frame_start position, frame period and bright count
    @(negedge clk);
    rst_b = 1'b1;
    guard = 0;
    while (!b_fs && guard < 2000) begin step(); guard++; end
    check("b_first_fs_k", kb, B_CD * B_HT * B_VT + 1);
    k0 = kb;
    brc = 0;
    guard = 0;
    do begin
      step();
      guard++;
      if (b_br) brc++;
    end while (!b_fs && guard < 2000);
    check("b_fs_period", kb - k0, B_CD * B_HT * B_VT);
    check("b_bright_clks", brc, B_CD * B_HA * B_VA);

    // Mid-frame reset is asynchronous and the raster restarts cleanly
    guard = 0;
    while (!(b_h == 10'd12 && b_v == 10'd7) && guard < 2000) begin step(); guard++; end
    check("b_midrst_pos", {b_h, b_v}, {10'd12, 10'd7});
    #2;
    rst_b = 1'b0;
    #1;
    check("b_midrst_async", b_obs, '0);
    step(); step(); step();
    #1;
    rst_b = 1'b1;
    for (int i = 0; i < B_CD + 1; i++) step();
    check("b_restart_h1", {b_tick, b_h}, {1'b0, 10'd1});

    // Reduced raster C with CLK_DIV=1: tick every clock, three frames
    @(negedge clk);
    rst_c = 1'b1;
    tks = 0;
    for (int i = 0; i < 50; i++) begin step(); if (c_tick) tks++; end
    check("c_tick_const", tks, 50);
    for (int f = 0; f < 3; f++) begin
      guard = 0;
      while (!c_fs && guard < 1000) begin step(); guard++; end
      check($sformatf("c_fs%0d_k", f), kc, C_HT * C_VT * (f + 1) + 1);
      step();
    end
`ifdef VGA_FRAME_COUNT_EN
    check("c_fcnt3", c_fc, 16'd3);
`endif

    // Random asynchronous reset pulses on B and C, checked cycle by cycle
    for (int i = 0; i < 12000; i++) begin
      step();
      #($urandom_range(1, 8));
      rst_b = ($urandom_range(0, 1499) != 0);
      rst_c = ($urandom_range(0, 699) != 0);
    end
    @(negedge clk);
    rst_b = 1'b1;
    rst_c = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
